// File: rtl/pipeline_pkg.sv
// Shared types and widths for the memory stage (EX/MEM register, data-memory
// handshake, MEM/WB register).
package pipeline_pkg;

    localparam int DATA_W         = 22;
    localparam int RA_W           = 4;
    localparam int TIMEOUT_CYCLES = 15;

    // Controls carried through EX/MEM
    typedef struct packed {
        logic pc_src;
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
    } mem_ctrl_t;

    // Controls carried through MEM/WB
    typedef struct packed {
        logic pc_src;
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } dmem_state_t;

    // Drop the controls that are consumed in M before handing them to W
    function automatic wb_ctrl_t to_wb_ctrl(input mem_ctrl_t c);
        wb_ctrl_t w;
        w.pc_src     = c.pc_src;
        w.reg_write  = c.reg_write;
        w.mem_to_reg = c.mem_to_reg;
        return w;
    endfunction

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory req/ack controller: access FSM, wait counter and optional abort.
// Optional feature: define DMEM_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES wait cycles and raise a sticky error flag.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | no access outstanding; a new mem op may start this cycle
//  ACCESS | mem op in EX/MEM has been requested and is waiting for ack
module dmem_handshake #(
    parameter int TIMEOUT_CYCLES = pipeline_pkg::TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_op_i,
    input  logic ack_i,
    output logic dmem_req_o,
    output logic stall_o,
    output logic ack_take_o,
    output logic abort_o,
    output logic mem_error_o
);
    import pipeline_pkg::*;

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    dmem_state_t       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout;

`ifdef DMEM_TIMEOUT_EN
    logic err_q, err_d;

    // Abort only when the wait budget is used up and the RAM still has not answered
    assign timeout     = mem_op_i && (state_q == ACCESS) && !ack_i &&
                         (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES));
    assign err_d       = err_q | timeout;
    assign mem_error_o = err_q;

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end
`else
    assign timeout     = 1'b0;
    assign mem_error_o = 1'b0;
`endif

    // Request and stall come straight from the EX/MEM register so a zero-wait RAM costs no cycle
    assign dmem_req_o = mem_op_i & ~timeout;
    assign stall_o    = mem_op_i & ~ack_i & ~timeout;
    assign ack_take_o = mem_op_i & ack_i;
    assign abort_o    = timeout;

    // Next state and wait count; the count covers every unacknowledged cycle of the access
    always_comb begin
        state_d    = IDLE;
        wait_cnt_d = '0;
        if (stall_o) begin
            state_d = ACCESS;
            if (state_q == ACCESS)
                wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
            else
                wait_cnt_d = WAIT_W'(1);
        end
    end

    // FSM and wait counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: EX/MEM pipeline register, data-memory access control and
// MEM/WB pipeline register. Stalls the front of the pipe while a data access
// waits for ack.
// Optional feature: define DMEM_TIMEOUT_EN to abort stuck accesses.
module memory_stage #(
    parameter int DATA_W         = pipeline_pkg::DATA_W,
    parameter int RA_W           = pipeline_pkg::RA_W,
    parameter int TIMEOUT_CYCLES = pipeline_pkg::TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_result_e,
    input  logic [DATA_W-1:0] write_data_e,
    input  logic [RA_W-1:0]   wa3_e,
    input  logic              pc_src_e,
    input  logic              reg_write_e,
    input  logic              mem_write_e,
    input  logic              mem_to_reg_e,
    input  logic              flush_m,
    output logic [DATA_W-1:0] alu_result_memory,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_mem,
    output logic [DATA_W-1:0] read_data_w,
    output logic [DATA_W-1:0] alu_result_w,
    output logic [RA_W-1:0]   wa3_w,
    output logic              reg_write_w,
    output logic              mem_to_reg_w,
    output logic              pc_src_w,
    output logic              mem_error
);
    import pipeline_pkg::*;

    mem_ctrl_t         ctrl_m_q;
    logic [DATA_W-1:0] alu_m_q;
    logic [DATA_W-1:0] wdata_m_q;
    logic [RA_W-1:0]   wa3_m_q;

    wb_ctrl_t          ctrl_w_q;
    logic [DATA_W-1:0] alu_w_q;
    logic [DATA_W-1:0] rdata_w_q;
    logic [RA_W-1:0]   wa3_w_q;

    logic mem_op;
    logic ack_take;
    logic abort;

    assign mem_op = ctrl_m_q.mem_write | ctrl_m_q.mem_to_reg;

    dmem_handshake #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_hs (
        .clk         (clk),
        .rst         (rst),
        .mem_op_i    (mem_op),
        .ack_i       (dmem_ack),
        .dmem_req_o  (dmem_req),
        .stall_o     (stall_mem),
        .ack_take_o  (ack_take),
        .abort_o     (abort),
        .mem_error_o (mem_error)
    );

    // Address, data and direction come from the held EX/MEM register, so they stay stable while stalled
    assign alu_result_memory = alu_m_q;
    assign dmem_addr         = alu_m_q;
    assign dmem_wdata        = wdata_m_q;
    assign dmem_we           = ctrl_m_q.mem_write;

    assign alu_result_w = alu_w_q;
    assign read_data_w  = rdata_w_q;
    assign wa3_w        = wa3_w_q;
    assign reg_write_w  = ctrl_w_q.reg_write;
    assign mem_to_reg_w = ctrl_w_q.mem_to_reg;
    assign pc_src_w     = ctrl_w_q.pc_src;

    // EX/MEM register: advances unless stalled; a flush turns the incoming op into a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_m_q  <= '0;
            alu_m_q   <= '0;
            wdata_m_q <= '0;
            wa3_m_q   <= '0;
        end else if (!stall_mem) begin
            alu_m_q   <= alu_result_e;
            wdata_m_q <= write_data_e;
            wa3_m_q   <= wa3_e;
            if (flush_m) begin
                ctrl_m_q <= '0;
            end else begin
                ctrl_m_q.pc_src     <= pc_src_e;
                ctrl_m_q.reg_write  <= reg_write_e;
                ctrl_m_q.mem_write  <= mem_write_e;
                ctrl_m_q.mem_to_reg <= mem_to_reg_e;
            end
        end
    end

    // MEM/WB register: bubbles while stalled so a waiting op writes back exactly once; aborted ops never write back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_w_q <= '0;
            alu_w_q  <= '0;
            wa3_w_q  <= '0;
        end else if (stall_mem) begin
            ctrl_w_q <= '0;
        end else begin
            alu_w_q  <= alu_m_q;
            wa3_w_q  <= wa3_m_q;
            ctrl_w_q <= abort ? wb_ctrl_t'('0) : to_wb_ctrl(ctrl_m_q);
        end
    end

    // Load data is captured only on the cycle the RAM acknowledges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          rdata_w_q <= '0;
        else if (ack_take) rdata_w_q <= dmem_rdata;
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: scoreboard of expected write-backs plus a small
// variable-latency RAM model that checks request stability.
module tb_memory_stage;
    import pipeline_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] alu_result_e = '0;
    logic [DATA_W-1:0] write_data_e = '0;
    logic [RA_W-1:0]   wa3_e = '0;
    logic              pc_src_e = 1'b0;
    logic              reg_write_e = 1'b0;
    logic              mem_write_e = 1'b0;
    logic              mem_to_reg_e = 1'b0;
    logic              flush_m = 1'b0;
    logic [DATA_W-1:0] alu_result_memory;
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata = '0;
    logic              dmem_ack = 1'b0;
    logic              stall_mem;
    logic [DATA_W-1:0] read_data_w;
    logic [DATA_W-1:0] alu_result_w;
    logic [RA_W-1:0]   wa3_w;
    logic              reg_write_w;
    logic              mem_to_reg_w;
    logic              pc_src_w;
    logic              mem_error;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk               (clk),
        .rst               (rst),
        .alu_result_e      (alu_result_e),
        .write_data_e      (write_data_e),
        .wa3_e             (wa3_e),
        .pc_src_e          (pc_src_e),
        .reg_write_e       (reg_write_e),
        .mem_write_e       (mem_write_e),
        .mem_to_reg_e      (mem_to_reg_e),
        .flush_m           (flush_m),
        .alu_result_memory (alu_result_memory),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_rdata        (dmem_rdata),
        .dmem_ack          (dmem_ack),
        .stall_mem         (stall_mem),
        .read_data_w       (read_data_w),
        .alu_result_w      (alu_result_w),
        .wa3_w             (wa3_w),
        .reg_write_w       (reg_write_w),
        .mem_to_reg_w      (mem_to_reg_w),
        .pc_src_w          (pc_src_w),
        .mem_error         (mem_error)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [DATA_W-1:0] alu;
        logic [RA_W-1:0]   wa3;
        logic              pc;
        logic              rw;
        logic              m2r;
        logic [DATA_W-1:0] rdata;
    } wb_exp_t;

    typedef struct {
        int                waits;
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } ram_txn_t;

    wb_exp_t  wb_q[$];
    ram_txn_t ram_q[$];

    // RAM model: acks after the programmed number of wait cycles, checks request stability
    int       waited = 0;
    logic     busy = 1'b0;
    logic     late_ack = 1'b0;
    ram_txn_t cur;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            busy     = 1'b0;
            waited   = 0;
            dmem_ack = 1'b0;
        end else if (dmem_req) begin
            if (!busy) begin
                if (ram_q.size() == 0) begin
                    check("ram_unexpected_req", {31'd0, dmem_req}, 32'd0);
                end else begin
                    cur    = ram_q.pop_front();
                    busy   = 1'b1;
                    waited = 0;
                    check("ram_addr", 32'(dmem_addr), 32'(cur.addr));
                    check("ram_we", {31'd0, dmem_we}, {31'd0, cur.we});
                    if (cur.we) check("ram_wdata", 32'(dmem_wdata), 32'(cur.wdata));
                end
            end else begin
                check("ram_addr_stable", 32'(dmem_addr), 32'(cur.addr));
                check("ram_we_stable", {31'd0, dmem_we}, {31'd0, cur.we});
                if (cur.we) check("ram_wdata_stable", 32'(dmem_wdata), 32'(cur.wdata));
            end
            if (busy) begin
                if (waited == cur.waits) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = cur.rdata;
                    busy       = 1'b0;
                end else begin
                    dmem_ack = 1'b0;
                    waited++;
                end
            end else begin
                dmem_ack = 1'b0;
            end
        end else begin
            busy     = 1'b0;
            dmem_ack = late_ack;
        end
    end

    // Write-back monitor: every non-bubble MEM/WB entry must match the next expected op
    always @(posedge clk) begin
        wb_exp_t e;
        #1;
        if (rst && (reg_write_w || mem_to_reg_w || pc_src_w)) begin
            if (wb_q.size() == 0) begin
                check("wb_extra", {29'd0, reg_write_w, mem_to_reg_w, pc_src_w}, 32'd0);
            end else begin
                e = wb_q.pop_front();
                check("wb_alu", 32'(alu_result_w), 32'(e.alu));
                check("wb_wa3", 32'(wa3_w), 32'(e.wa3));
                check("wb_reg_write", {31'd0, reg_write_w}, {31'd0, e.rw});
                check("wb_mem_to_reg", {31'd0, mem_to_reg_w}, {31'd0, e.m2r});
                check("wb_pc_src", {31'd0, pc_src_w}, {31'd0, e.pc});
                if (e.m2r) check("wb_read_data", 32'(read_data_w), 32'(e.rdata));
            end
        end
    end

    int stall_cycles = 0;
    int req_cycles = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (stall_mem) stall_cycles++;
            if (dmem_req)  req_cycles++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one op, wait until EX/MEM accepts it, record what the model expects downstream
    task automatic issue(input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] wd,
                         input logic [RA_W-1:0] wa3, input logic pc, input logic rw,
                         input logic mw, input logic m2r, input int waits,
                         input logic [DATA_W-1:0] rdata, input logic flush);
        int n;
        wb_exp_t  e;
        ram_txn_t r;
        alu_result_e = alu; write_data_e = wd; wa3_e = wa3;
        pc_src_e = pc; reg_write_e = rw; mem_write_e = mw; mem_to_reg_e = m2r;
        flush_m = flush;
        n = 0;
        @(negedge clk);
        while (stall_mem && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("issue_wait_bound", {31'd0, stall_mem}, 32'd0);
        if (!flush) begin
            if (rw || pc || m2r) begin
                e.alu = alu; e.wa3 = wa3; e.pc = pc; e.rw = rw; e.m2r = m2r; e.rdata = rdata;
                wb_q.push_back(e);
            end
            if (mw || m2r) begin
                r.waits = waits; r.we = mw; r.addr = alu; r.wdata = wd; r.rdata = rdata;
                ram_q.push_back(r);
            end
        end
        @(posedge clk);
        #1;
        pc_src_e = 1'b0; reg_write_e = 1'b0; mem_write_e = 1'b0; mem_to_reg_e = 1'b0;
        flush_m = 1'b0;
    endtask

    initial begin
        int s0, r0;
        #2 rst = 1'b0;
        idle(2);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_stall", {31'd0, stall_mem}, 32'd0);
        check("rst_mem_error", {31'd0, mem_error}, 32'd0);
        check("rst_alu_m", 32'(alu_result_memory), 32'd0);
        check("rst_reg_write_w", {31'd0, reg_write_w}, 32'd0);
        rst = 1'b1;
        idle(1);

        // ALU op: visible in M after one edge, in W after two, no stall
        s0 = stall_cycles;
        issue(22'h00055, 22'h0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 0, 22'h0, 1'b0);
        check("t1_alu_m", 32'(alu_result_memory), 32'h55);
        idle(3);
        check("t1_stall", 32'(stall_cycles - s0), 32'd0);

        // Zero-wait load
        s0 = stall_cycles; r0 = req_cycles;
        issue(22'h00010, 22'h0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 0, 22'h3ABCD, 1'b0);
        idle(3);
        check("t2_req_cycles", 32'(req_cycles - r0), 32'd1);
        check("t2_stall", 32'(stall_cycles - s0), 32'd0);

        // Store with three wait cycles
        s0 = stall_cycles; r0 = req_cycles;
        issue(22'h00020, 22'h00777, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 22'h0, 1'b0);
        idle(6);
        check("t3_stall", 32'(stall_cycles - s0), 32'd3);
        check("t3_req_cycles", 32'(req_cycles - r0), 32'd4);

        // Back-to-back loads, one wait each
        s0 = stall_cycles; r0 = req_cycles;
        issue(22'h00030, 22'h0, 4'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1, 22'h11111, 1'b0);
        issue(22'h00031, 22'h0, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1, 22'h22222, 1'b0);
        idle(5);
        check("t4_req_cycles", 32'(req_cycles - r0), 32'd4);
        check("t4_stall", 32'(stall_cycles - s0), 32'd2);

        // Waiting load followed directly by an ALU op and a branch; then a flushed op
        issue(22'h2ABCD, 22'h0, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1, 2, 22'h15A5A, 1'b0);
        issue(22'h1F00F, 22'h0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 22'h0, 1'b0);
        issue(22'h00044, 22'h0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 22'h0, 1'b0);
        issue(22'h00099, 22'h0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 0, 22'h0, 1'b1);
        idle(4);

        // Reset in the middle of a waiting access
        issue(22'h00040, 22'h0, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1, 8, 22'h0ABCD, 1'b0);
        idle(2);
        #1 rst = 1'b0;
        #1;
        check("t5_req_async", {31'd0, dmem_req}, 32'd0);
        check("t5_stall_async", {31'd0, stall_mem}, 32'd0);
        wb_q.delete();
        ram_q.delete();
        idle(1);
        rst = 1'b1;
        check("t5_alu_m", 32'(alu_result_memory), 32'd0);
        check("t5_alu_w", 32'(alu_result_w), 32'd0);
        check("t5_read_data_w", 32'(read_data_w), 32'd0);
        check("t5_wa3_w", 32'(wa3_w), 32'd0);
        check("t5_wb_ctrl", {29'd0, reg_write_w, mem_to_reg_w, pc_src_w}, 32'd0);
        check("t5_mem_error", {31'd0, mem_error}, 32'd0);
        check("t5_state", {31'd0, dut.u_hs.state_q}, {31'd0, IDLE});
        idle(2);
        check("t5_req_after", {31'd0, dmem_req}, 32'd0);

`ifdef DMEM_TIMEOUT_EN
        // Load that never gets an ack: abort after the wait budget, then a late ack is ignored
        s0 = stall_cycles; r0 = req_cycles;
        issue(22'h00050, 22'h0, 4'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1000, 22'h0, 1'b0);
        idle(25);
        check("t6_stall", 32'(stall_cycles - s0), 32'd15);
        check("t6_req_cycles", 32'(req_cycles - r0), 32'd15);
        check("t6_mem_error", {31'd0, mem_error}, 32'd1);
        late_ack = 1'b1;
        issue(22'h00060, 22'h0, 4'd11, 1'b0, 1'b1, 1'b0, 1'b0, 0, 22'h0, 1'b0);
        idle(2);
        late_ack = 1'b0;
        check("t6_mem_error_sticky", {31'd0, mem_error}, 32'd1);
        check("t6_stall_after", {31'd0, stall_mem}, 32'd0);
        idle(2);
`else
        check("mem_error_tied", {31'd0, mem_error}, 32'd0);
`endif

        idle(3);
        check("sb_wb_empty", 32'(wb_q.size()), 32'd0);
        check("sb_ram_empty", 32'(ram_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
